// File: rtl/vga_if.sv
// vga_if: raster bundle between the timing generator (master) and its
// consumers (slave: pixel source / DAC front end).
//   run     consumer -> generator  1 = produce raster, 0 = hold at (0,0)
//   pix_en  generator -> consumer  pixel tick strobe
//   hcnt/vcnt                      raw raster counters
//   hs/vs/de                       syncs and display enable
//   x/y                            active-area coordinates (0 in blanking)
//   sol/sof                        start of line / start of frame strobes
//   rgb                            {R,G,B} test pattern or 0
interface vga_if #(
  parameter int CW = 11
);
  logic          run;
  logic          pix_en;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hs;
  logic          vs;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          sol;
  logic          sof;
  logic [23:0]   rgb;

  modport master (
    input  run,
    output pix_en, hcnt, vcnt, hs, vs, de, x, y, sol, sof, rgb
  );

  modport slave (
    output run,
    input  pix_en, hcnt, vcnt, hs, vs, de, x, y, sol, sof, rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// One H/V counter pair plus an optional pixel-tick divider. Every output is
// a flop loaded with the decode of the *next* count, so outputs always agree
// with hcnt/vcnt and nothing is combinational from run.
// Ports:
//   clk  pixel-domain clock
//   rst  asynchronous reset, active-high
//   vif  vga_if.master (run in; pix_en, hcnt, vcnt, hs, vs, de, x, y,
//        sol, sof, rgb out)
// Build option: define VGA_TESTPAT_EN to get the registered test pattern on
// rgb (R=x, G=y, B=255-x in the active area); otherwise rgb is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11,
  parameter int PIX_DIV  = 1
) (
  input logic clk,
  input logic rst,
  vga_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be 1..16");
  end

  logic          run_q;
  logic [DW-1:0] div_q, div_n;
  logic          pe_q, pe_n;
  logic [CW-1:0] h_q, v_q, h_n, v_n;
  logic          de_q, hs_q, vs_q, sol_q, sof_q;
  logic [CW-1:0] x_q, y_q;
  logic          de_n, hs_act, vs_act;
  int            h_i, v_i;

  always_comb begin
    // On the first run cycle (run_q low) the divider stays at 0 so the
    // opening (0,0) tick lasts a full PIX_DIV clocks.
    div_n = '0;
    if (vif.run && run_q && div_q != DIV_LAST) div_n = div_q + 1'b1;
    pe_n = vif.run && (div_n == DIV_LAST);

    h_n = h_q;
    v_n = v_q;
    if (!vif.run) begin
      h_n = '0;
      v_n = '0;
    end else if (pe_q) begin
      if (h_q == H_LAST) begin
        h_n = '0;
        v_n = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_n = h_q + 1'b1;
      end
    end

    h_i    = int'(h_n);
    v_i    = int'(v_n);
    de_n   = vif.run && (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
    hs_act = vif.run && (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
    vs_act = vif.run && (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= '0;
      pe_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      sol_q <= 1'b0;
      sof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      run_q <= vif.run;
      div_q <= div_n;
      pe_q  <= pe_n;
      h_q   <= h_n;
      v_q   <= v_n;
      de_q  <= de_n;
      hs_q  <= hs_act ? HS_POL : ~HS_POL;
      vs_q  <= vs_act ? VS_POL : ~VS_POL;
      sol_q <= vif.run && (h_n == '0);
      sof_q <= vif.run && (h_n == '0) && (v_n == '0);
      x_q   <= de_n ? h_n : '0;
      y_q   <= de_n ? v_n : '0;
    end
  end

  assign vif.pix_en = pe_q;
  assign vif.hcnt   = h_q;
  assign vif.vcnt   = v_q;
  assign vif.de     = de_q;
  assign vif.hs     = hs_q;
  assign vif.vs     = vs_q;
  assign vif.sol    = sol_q;
  assign vif.sof    = sof_q;
  assign vif.x      = x_q;
  assign vif.y      = y_q;

`ifdef VGA_TESTPAT_EN
  logic [7:0]  xr, yr;
  logic [23:0] rgb_q;

  assign xr = 8'(h_n);
  assign yr = 8'(v_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= de_n ? {xr, yr, 8'd255 - xr} : 24'h0;
  end

  assign vif.rgb = rgb_q;
`else
  assign vif.rgb = 24'h0;
`endif
endmodule
